// File: rtl/mem_pkg.sv
// Purpose: shared encodings for the MOV/MOC memory responder (sizes, RW, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  // Access size encodings; 2'b11 is reserved and handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // RW encodings
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of the latency countdown (LATENCY is limited to 1..15)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_byte_array.sv
// Purpose: 2^ADDR_W-byte RAM exposing four consecutive byte lanes at addr..addr+3 (wrapping).
// Latency: read is combinational at addr; write commits on the rising edge.
// Backpressure: none; a write happens on every edge where a lane enable is set.
//
// Ports: clk; addr = base byte address; wr_en[i] writes lane i (byte at addr+i);
//        wr_dat/rd_dat are big-endian: lane 0 occupies bits [31:24].
module mem_byte_array #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        wr_en,
  input  logic [31:0]       wr_dat,
  output logic [31:0]       rd_dat
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are deliberately not reset so they survive a reset pulse.
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  // Lane addresses wrap naturally modulo 2^ADDR_W through the truncating add.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = addr + ADDR_W'(i);
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < 4; i++) begin
      rd_dat[31-8*i -: 8] = mem[lane_addr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem[lane_addr[i]] <= wr_dat[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Purpose: MOV/MOC memory responder; big-endian byte/half/word access to an internal RAM.
// Latency: MOV sampled at edge N gives MOC (with data_out/mem_err) after edge N+LATENCY.
// Backpressure: level handshake; MOC holds while MOV is high, one new request per LATENCY+2 cycles.
//
// Ports: clk, reset_n (async active-low); MOV/RW/MAR/MDR_in/size/sign_ext request inputs,
//        sampled only in IDLE; MOC completion, data_out read data, mem_err misalignment flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MOV,
  input  logic        RW,
  input  logic [31:0] MAR,
  input  logic [31:0] MDR_in,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        MOC,
  output logic [31:0] data_out,
  output logic        mem_err
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              sx_q;
  logic [31:0]       wdat_q;

  // Upper address bits alias away.
  logic unused_mar;
  assign unused_mar = ^MAR[31:ADDR_W];

  // Access fields: live inputs while in IDLE (needed when LATENCY = 1 completes
  // on the capture edge), registered copies otherwise.
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_rw;
  logic [1:0]        cur_size;
  logic              cur_sx;
  logic [31:0]       cur_wdat;

  always_comb begin
    cur_addr = addr_q;
    cur_rw   = rw_q;
    cur_size = size_q;
    cur_sx   = sx_q;
    cur_wdat = wdat_q;
    if (state == IDLE) begin
      cur_addr = MAR[ADDR_W-1:0];
      cur_rw   = RW;
      cur_size = size;
      cur_sx   = sign_ext;
      cur_wdat = MDR_in;
    end
  end

  // The edge that enters DONE is the edge that performs the access.
  logic go_done;
  assign go_done = ((state == IDLE) && MOV && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == '0));

  // Sizes 10 and 11 are both word accesses, hence the test on size[1].
  logic misaligned;
  assign misaligned = ((cur_size == SZ_HALF) && cur_addr[0]) ||
                      (cur_size[1] && (cur_addr[1:0] != 2'b00));

  logic [3:0]  wr_en;
  logic [31:0] wr_dat;
  logic [31:0] rd_dat;
  logic [31:0] rd_ext;

  // Right-justified write data is moved to the top lanes (big-endian: lane 0 = MSB).
  always_comb begin
    wr_en  = 4'b0000;
    wr_dat = cur_wdat;
    case (cur_size)
      SZ_BYTE: begin
        wr_en  = 4'b0001;
        wr_dat = {cur_wdat[7:0], 24'h0};
      end
      SZ_HALF: begin
        wr_en  = 4'b0011;
        wr_dat = {cur_wdat[15:0], 16'h0};
      end
      default: begin
        wr_en  = 4'b1111;
        wr_dat = cur_wdat;
      end
    endcase
    // reset_n gating keeps an aborted request from touching the RAM.
    if (!(go_done && (cur_rw == RW_WRITE) && !misaligned && reset_n)) begin
      wr_en = 4'b0000;
    end
  end

  always_comb begin
    case (cur_size)
      SZ_BYTE: rd_ext = {{24{cur_sx & rd_dat[31]}}, rd_dat[31:24]};
      SZ_HALF: rd_ext = {{16{cur_sx & rd_dat[31]}}, rd_dat[31:16]};
      default: rd_ext = rd_dat;
    endcase
  end

  mem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .addr   (cur_addr),
    .wr_en  (wr_en),
    .wr_dat (wr_dat),
    .rd_dat (rd_dat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      rw_q     <= RW_READ;
      size_q   <= SZ_BYTE;
      sx_q     <= 1'b0;
      wdat_q   <= '0;
      MOC      <= 1'b0;
      mem_err  <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            addr_q <= MAR[ADDR_W-1:0];
            rw_q   <= RW;
            size_q <= size;
            sx_q   <= sign_ext;
            wdat_q <= MDR_in;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!MOV) begin
            MOC     <= 1'b0;
            mem_err <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (go_done) begin
        MOC     <= 1'b1;
        mem_err <= misaligned;
        if ((cur_rw == RW_READ) && !misaligned) begin
          data_out <= rd_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: directed self-checking bench for mem_responder (ADDR_W = 9, LATENCY = 2).
// Latency: expects MOC two edges after the MOV capture edge.
// Backpressure: drives the level MOV/MOC handshake, dropping MOV after MOC.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mov = 1'b0;
  logic        rw = 1'b1;
  logic [31:0] mar = '0;
  logic [31:0] mdr = '0;
  logic [1:0]  sz = 2'b10;
  logic        sx = 1'b0;
  logic        moc;
  logic [31:0] data_out;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W  (9),
    .LATENCY (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .MOV      (mov),
    .RW       (rw),
    .MAR      (mar),
    .MDR_in   (mdr),
    .size     (sz),
    .sign_ext (sx),
    .MOC      (moc),
    .data_out (data_out),
    .mem_err  (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request, scramble the request inputs after capture, and wait for MOC.
  // Checks that MOC appears exactly two edges after the capture edge.
  task automatic start_req(input string tag, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s, input logic x);
    int edges;
    @(negedge clk);
    mov = 1'b1; rw = r; mar = a; mdr = d; sz = s; sx = x;
    @(posedge clk);               // capture edge
    #2;
    rw = ~r; mar = ~a; mdr = ~d; sz = ~s; sx = ~x;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!moc && edges < 20);
    check({tag, " latency"}, 32'(edges), 32'd2);
  endtask

  // MOC must hold while MOV is high, then drop with mem_err one edge after MOV falls.
  task automatic end_req(input string tag);
    @(posedge clk);
    #1;
    check({tag, " moc hold"}, {31'b0, moc}, 32'd1);
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " moc fall"}, {31'b0, moc}, 32'd0);
    check({tag, " err fall"}, {31'b0, mem_err}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset moc", {31'b0, moc}, 32'd0);
    check("reset data", data_out, 32'h0);
    check("reset err", {31'b0, mem_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Word write then word read
    start_req("wr 010", 1'b0, 32'h010, 32'hDEADBEEF, 2'b10, 1'b0);
    check("wr 010 err", {31'b0, mem_err}, 32'd0);
    end_req("wr 010");
    start_req("rd 010", 1'b1, 32'h010, 32'h0, 2'b10, 1'b0);
    check("rd 010 data", data_out, 32'hDEADBEEF);
    check("rd 010 err", {31'b0, mem_err}, 32'd0);
    end_req("rd 010");

    // Signed byte reads (big-endian order)
    start_req("rdb 010", 1'b1, 32'h010, 32'h0, 2'b00, 1'b1);
    check("rdb 010 data", data_out, 32'hFFFFFFDE);
    end_req("rdb 010");
    start_req("rdb 011", 1'b1, 32'h011, 32'h0, 2'b00, 1'b1);
    check("rdb 011 data", data_out, 32'hFFFFFFAD);
    end_req("rdb 011");
    start_req("rdb 012", 1'b1, 32'h012, 32'h0, 2'b00, 1'b1);
    check("rdb 012 data", data_out, 32'hFFFFFFBE);
    end_req("rdb 012");
    start_req("rdb 013", 1'b1, 32'h013, 32'h0, 2'b00, 1'b1);
    check("rdb 013 data", data_out, 32'hFFFFFFEF);
    end_req("rdb 013");

    // Unsigned half read
    start_req("rdh 012", 1'b1, 32'h012, 32'h0, 2'b01, 1'b0);
    check("rdh 012 data", data_out, 32'h0000BEEF);
    end_req("rdh 012");

    // Misaligned word write: error, no RAM update, data_out untouched
    start_req("wr 012", 1'b0, 32'h012, 32'h12345678, 2'b10, 1'b0);
    check("wr 012 err", {31'b0, mem_err}, 32'd1);
    check("wr 012 data", data_out, 32'h0000BEEF);
    end_req("wr 012");
    start_req("rd2 010", 1'b1, 32'h010, 32'h0, 2'b10, 1'b0);
    check("rd2 010 data", data_out, 32'hDEADBEEF);
    end_req("rd2 010");

    // MOV dropped during WAIT: request still completes with a one-cycle MOC pulse
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; mar = 32'h020; mdr = 32'h0000005A; sz = 2'b00; sx = 1'b0;
    @(posedge clk);               // capture
    #1;
    check("drop moc capt", {31'b0, moc}, 32'd0);
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk);
    #1;
    check("drop moc wait", {31'b0, moc}, 32'd0);
    @(posedge clk);
    #1;
    check("drop moc pulse", {31'b0, moc}, 32'd1);
    check("drop data", data_out, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    check("drop moc end", {31'b0, moc}, 32'd0);
    start_req("rdb 020", 1'b1, 32'h020, 32'h0, 2'b00, 1'b0);
    check("rdb 020 data", data_out, 32'h0000005A);
    end_req("rdb 020");

    // Known content at 0x030, then a write aborted by reset during WAIT
    start_req("wr 030", 1'b0, 32'h030, 32'hCAFEF00D, 2'b10, 1'b0);
    end_req("wr 030");
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; mar = 32'h030; mdr = 32'h11223344; sz = 2'b10;
    @(posedge clk);               // capture
    #2;
    reset_n = 1'b0;
    mov = 1'b0;
    #1;
    check("abort data", data_out, 32'h0);
    check("abort moc", {31'b0, moc}, 32'd0);
    check("abort err", {31'b0, mem_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort no moc", {31'b0, moc}, 32'd0);
    start_req("rd 030", 1'b1, 32'h030, 32'h0, 2'b10, 1'b0);
    check("rd 030 data", data_out, 32'hCAFEF00D);
    end_req("rd 030");

    // Address aliasing and top-of-memory word
    start_req("rd alias", 1'b1, 32'h80000010, 32'h0, 2'b10, 1'b0);
    check("rd alias data", data_out, 32'hDEADBEEF);
    end_req("rd alias");
    start_req("wr 1fc", 1'b0, 32'h1FC, 32'h0BADF00D, 2'b10, 1'b0);
    end_req("wr 1fc");
    start_req("rd 1fc", 1'b1, 32'h1FC, 32'h0, 2'b10, 1'b0);
    check("rd 1fc data", data_out, 32'h0BADF00D);
    end_req("rd 1fc");
    start_req("rdb 1ff", 1'b1, 32'h1FF, 32'h0, 2'b00, 1'b0);
    check("rdb 1ff data", data_out, 32'h0000000D);
    end_req("rdb 1ff");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
